// File: rtl/csin_rom_arbiter_if.sv
// rtl/csin_rom_arbiter_if.sv - request/response/ROM bundle for the two-port sine ROM arbiter
interface csin_rom_arbiter_if #(
  parameter int A_WIDTH = 16,
  parameter int D_WIDTH = 16
);
  logic               req0_valid;
  logic [A_WIDTH:0]   req0_adress;
  logic               req0_ready;
  logic               rsp0_valid;
  logic [D_WIDTH-1:0] rsp0_data;

  logic               req1_valid;
  logic [A_WIDTH:0]   req1_adress;
  logic               req1_ready;
  logic               rsp1_valid;
  logic [D_WIDTH-1:0] rsp1_data;

  logic [A_WIDTH:0]   rom_adress;
  logic               rom_re_s;
  logic [D_WIDTH-1:0] rom_data;

  // Requesters and the ROM together drive the arbiter's inputs.
  modport master (
    output req0_valid, req0_adress, req1_valid, req1_adress, rom_data,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  rom_adress, rom_re_s
  );

  modport slave (
    input  req0_valid, req0_adress, req1_valid, req1_adress, rom_data,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output rom_adress, rom_re_s
  );
endinterface

// File: rtl/csin_rom_arbiter.sv
// rtl/csin_rom_arbiter.sv - round-robin arbiter sharing one sine/cosine ROM between two requesters
module csin_rom_arbiter #(
  parameter int A_WIDTH = 16,
  parameter int D_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  csin_rom_arbiter_if.slave    bus
);

  logic               last_grant;   // 1: requester 1 granted most recently
  logic               grant0;
  logic               grant1;
  logic [A_WIDTH:0]   addr_mux;

  logic               p1_valid;
  logic               p1_id;

  logic               rsp0_valid_q;
  logic               rsp1_valid_q;
  logic [D_WIDTH-1:0] rsp0_data_q;
  logic [D_WIDTH-1:0] rsp1_data_q;

  // Grants are gated by rst so nothing is accepted while the pipeline is held clear.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    addr_mux = '0;
    if (grant0) begin
      addr_mux = bus.req0_adress;
    end else if (grant1) begin
      addr_mux = bus.req1_adress;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rom_re_s   = grant0 | grant1;
  assign bus.rom_adress = addr_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Stage 1 tracks which requester owns the ROM word arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_id    <= 1'b0;
    end else begin
      p1_valid <= grant0 | grant1;
      p1_id    <= grant1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= p1_valid && !p1_id;
      rsp1_valid_q <= p1_valid && p1_id;
      if (p1_valid && !p1_id) begin
        rsp0_data_q <= bus.rom_data;
      end
      if (p1_valid && p1_id) begin
        rsp1_data_q <= bus.rom_data;
      end
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;

endmodule
